// File: rtl/pbs_battle_ctrl.sv
// pbs_battle_ctrl: turn-sequencing controller for the PBS battle datapath.
// It turns a player confirm into one resolved player turn followed by an AI turn,
// drives the datapath strobes, and reports the battle outcome to display logic.
// Optional build macro: PBS_HEAL_LIMIT_EN limits heals to HEAL_MAX per battle.
// Outputs are registered: they are decoded from the next state and loaded on the
// same edge as the state register, so they always match the visible state.
module pbs_battle_ctrl #(
    parameter int unsigned MAX_TURNS = 15,
`ifdef PBS_HEAL_LIMIT_EN
    parameter int unsigned HEAL_MAX  = 3,
`endif
    parameter int unsigned AI_DELAY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [1:0] action,
    input  logic [1:0] move_sel,
    input  logic       ai_dead,
    input  logic       p_dead,
    input  logic       catch_success,
    output logic [1:0] p_move,
    output logic       actr,
    output logic       heal,
    output logic       catch,
    output logic       app_ai_dmg,
    output logic       app_pl_dmg,
    output logic       load_ai_hp,
    output logic       target,
    output logic       stop,
    output logic       dp_rst_n,
    output logic [3:0] state,
    output logic [3:0] turn_cnt,
    output logic       done,
    output logic [1:0] result,
    output logic       heal_denied
);

    typedef enum logic [3:0] {
        S_LOAD    = 4'd0,
        S_PWAIT   = 4'd1,
        S_PATK    = 4'd2,
        S_PCHK    = 4'd3,
        S_PHEAL   = 4'd4,
        S_PCATCH  = 4'd5,
        S_CCHK    = 4'd6,
        S_AIDLY   = 4'd7,
        S_AATK    = 4'd8,
        S_ACHK    = 4'd9,
        S_WIN     = 4'd10,
        S_LOSE    = 4'd11,
        S_CAUGHT  = 4'd12,
        S_TIMEOUT = 4'd13
    } state_t;

    // Moore output bundle, one field per registered output.
    typedef struct packed {
        logic       actr;
        logic       heal;
        logic       catch;
        logic       app_ai_dmg;
        logic       app_pl_dmg;
        logic       load_ai_hp;
        logic       target;
        logic       stop;
        logic       dp_rst_n;
        logic       done;
        logic [1:0] result;
    } out_t;

    // AI_DELAY of 0 and 1 both give a single cycle in S_AIDLY.
    localparam logic [3:0] DLY_LAST  = (AI_DELAY == 0) ? 4'd0 : 4'(AI_DELAY - 1);
    localparam logic [3:0] TURN_LAST = 4'(MAX_TURNS - 1);
    localparam logic [3:0] TURN_MAX  = 4'(MAX_TURNS);

    state_t     state_q, state_d;
    out_t       out_q, out_d;
    logic       go_q;
    logic       go_rise;
    logic [3:0] dly_q;
    logic [3:0] turn_q;
    logic [1:0] p_move_q;
    logic       heal_ok;

`ifdef PBS_HEAL_LIMIT_EN
    localparam int unsigned HEAL_W =
        ($clog2(HEAL_MAX + 1) < 2) ? 2 : $clog2(HEAL_MAX + 1);
    localparam logic [HEAL_W-1:0] HEAL_LIM = HEAL_W'(HEAL_MAX);

    logic [HEAL_W-1:0] heal_cnt_q;
    logic              heal_denied_q;

    assign heal_ok     = (heal_cnt_q != HEAL_LIM);
    assign heal_denied = heal_denied_q;
`else
    assign heal_ok     = 1'b1;
    assign heal_denied = 1'b0;
`endif

    assign go_rise = go & ~go_q;

    // Output decode for a given state; only ever called with a legal state.
    function automatic out_t decode(input state_t s);
        out_t o;
        o            = '0;
        o.stop       = 1'b1;
        o.dp_rst_n   = 1'b1;
        case (s)
            S_LOAD: begin
                o.dp_rst_n   = 1'b0;
                o.load_ai_hp = 1'b1;
            end
            S_PWAIT:  o.stop = 1'b0;
            S_PATK: begin
                o.target     = 1'b1;
                o.app_ai_dmg = 1'b1;
            end
            S_PHEAL:  o.heal = 1'b1;
            S_PCATCH: begin
                o.catch  = 1'b1;
                o.target = 1'b1;
            end
            S_AIDLY:  o.actr = 1'b1;
            S_AATK: begin
                o.actr       = 1'b1;
                o.app_pl_dmg = 1'b1;
            end
            S_ACHK:   o.actr = 1'b1;
            S_WIN: begin
                o.done   = 1'b1;
                o.result = 2'b00;
            end
            S_LOSE: begin
                o.done   = 1'b1;
                o.result = 2'b01;
            end
            S_CAUGHT: begin
                o.done   = 1'b1;
                o.result = 2'b10;
            end
            S_TIMEOUT: begin
                o.done   = 1'b1;
                o.result = 2'b11;
            end
            default: o.stop = 1'b1;
        endcase
        return o;
    endfunction

    // Next-state logic for the turn sequence.
    always_comb begin
        state_d = S_LOAD;
        case (state_q)
            S_LOAD:  state_d = S_PWAIT;
            S_PWAIT: begin
                state_d = S_PWAIT;
                if (go_rise) begin
                    unique case (action)
                        2'b00: state_d = S_PATK;
                        2'b01: state_d = heal_ok ? S_PHEAL : S_PWAIT;
                        2'b10: state_d = S_PCATCH;
                        2'b11: state_d = S_PWAIT;
                        default: state_d = S_PWAIT;
                    endcase
                end
            end
            S_PATK:   state_d = S_PCHK;
            S_PCHK:   state_d = ai_dead ? S_WIN : S_AIDLY;
            S_PHEAL:  state_d = S_AIDLY;
            S_PCATCH: state_d = S_CCHK;
            S_CCHK:   state_d = catch_success ? S_CAUGHT : S_AIDLY;
            S_AIDLY:  state_d = (dly_q == DLY_LAST) ? S_AATK : S_AIDLY;
            S_AATK:   state_d = S_ACHK;
            S_ACHK: begin
                if (p_dead) begin
                    state_d = S_LOSE;
                end else if (turn_q == TURN_LAST) begin
                    state_d = S_TIMEOUT;
                end else begin
                    state_d = S_PWAIT;
                end
            end
            S_WIN, S_LOSE, S_CAUGHT, S_TIMEOUT: state_d = go_rise ? S_LOAD : state_q;
            default:  state_d = S_LOAD;
        endcase
        out_d = decode(state_d);
    end

    // State, counters, move latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_LOAD;
            out_q    <= decode(S_LOAD);
            go_q     <= 1'b0;
            dly_q    <= 4'd0;
            turn_q   <= 4'd0;
            p_move_q <= 2'b00;
`ifdef PBS_HEAL_LIMIT_EN
            heal_cnt_q    <= '0;
            heal_denied_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            go_q    <= go;

            if (state_q == S_PWAIT && go_rise) begin
                p_move_q <= move_sel;
            end

            // Delay counter runs only while waiting for the AI and clears on exit.
            if (state_q == S_AIDLY && dly_q != DLY_LAST) begin
                dly_q <= dly_q + 4'd1;
            end else begin
                dly_q <= 4'd0;
            end

            // Rounds complete in S_ACHK when the player survives; saturates at MAX_TURNS.
            if (state_q == S_LOAD) begin
                turn_q <= 4'd0;
            end else if (state_q == S_ACHK && !p_dead && turn_q != TURN_MAX) begin
                turn_q <= turn_q + 4'd1;
            end

`ifdef PBS_HEAL_LIMIT_EN
            if (state_q == S_LOAD) begin
                heal_cnt_q <= '0;
            end else if (state_q == S_PHEAL && heal_ok) begin
                heal_cnt_q <= heal_cnt_q + 1'b1;
            end
            heal_denied_q <= (state_q == S_PWAIT) && go_rise && (action == 2'b01) && !heal_ok;
`endif
        end
    end

    assign state      = state_q;
    assign turn_cnt   = turn_q;
    assign p_move     = p_move_q;
    assign actr       = out_q.actr;
    assign heal       = out_q.heal;
    assign catch      = out_q.catch;
    assign app_ai_dmg = out_q.app_ai_dmg;
    assign app_pl_dmg = out_q.app_pl_dmg;
    assign load_ai_hp = out_q.load_ai_hp;
    assign target     = out_q.target;
    assign stop       = out_q.stop;
    assign dp_rst_n   = out_q.dp_rst_n;
    assign done       = out_q.done;
    assign result     = out_q.result;

endmodule

// File: tb/tb_pbs_battle_ctrl.sv
// Directed bench for pbs_battle_ctrl (MAX_TURNS=4, AI_DELAY=3).
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_pbs_battle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [1:0] action;
    logic [1:0] move_sel;
    logic       ai_dead;
    logic       p_dead;
    logic       catch_success;
    logic [1:0] p_move;
    logic       actr;
    logic       heal;
    logic       catch;
    logic       app_ai_dmg;
    logic       app_pl_dmg;
    logic       load_ai_hp;
    logic       target;
    logic       stop;
    logic       dp_rst_n;
    logic [3:0] state;
    logic [3:0] turn_cnt;
    logic       done;
    logic [1:0] result;
    logic       heal_denied;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    pbs_battle_ctrl #(
        .MAX_TURNS(4),
`ifdef PBS_HEAL_LIMIT_EN
        .HEAL_MAX(3),
`endif
        .AI_DELAY(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .action       (action),
        .move_sel     (move_sel),
        .ai_dead      (ai_dead),
        .p_dead       (p_dead),
        .catch_success(catch_success),
        .p_move       (p_move),
        .actr         (actr),
        .heal         (heal),
        .catch        (catch),
        .app_ai_dmg   (app_ai_dmg),
        .app_pl_dmg   (app_pl_dmg),
        .load_ai_hp   (load_ai_hp),
        .target       (target),
        .stop         (stop),
        .dp_rst_n     (dp_rst_n),
        .state        (state),
        .turn_cnt     (turn_cnt),
        .done         (done),
        .result       (result),
        .heal_denied  (heal_denied)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] a, input logic [1:0] m);
        action   = a;
        move_sel = m;
        go       = 1'b1;
        step(1);
        go       = 1'b0;
    endtask

    // Rematch from a terminal state back to a fresh S_PWAIT.
    task automatic rematch();
        press(2'b00, 2'b00);
        check("rm_load", state, 8'd0);
        check("rm_dprst", dp_rst_n, 8'd0);
        check("rm_ldhp", load_ai_hp, 8'd1);
        step(1);
        check("rm_pwait", state, 8'd1);
        check("rm_turn", turn_cnt, 8'd0);
    endtask

    // One unlimited heal round, ending back in S_PWAIT or in S_TIMEOUT.
    task automatic heal_round();
        press(2'b01, 2'b00);
        check("hr_state", state, 8'd4);
        check("hr_heal", heal, 8'd1);
        step(1);
        check("hr_dly", state, 8'd7);
        step(3);
        check("hr_aatk", state, 8'd8);
        check("hr_pldmg", app_pl_dmg, 8'd1);
        step(1);
        check("hr_achk", state, 8'd9);
        step(1);
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; action = 2'b00; move_sel = 2'b00;
        ai_dead = 1'b0; p_dead = 1'b0; catch_success = 1'b0;

        // Reset
        step(2);
        check("rst_state", state, 8'd0);
        check("rst_dprst", dp_rst_n, 8'd0);
        check("rst_ldhp", load_ai_hp, 8'd1);
        check("rst_stop", stop, 8'd1);
        check("rst_turn", turn_cnt, 8'd0);
        check("rst_pmove", p_move, 8'd0);
        check("rst_done", done, 8'd0);
        rst = 1'b1;
        step(1);
        check("pw_state", state, 8'd1);
        check("pw_stop", stop, 8'd0);
        check("pw_done", done, 8'd0);
        check("pw_ldhp", load_ai_hp, 8'd0);
        check("pw_dprst", dp_rst_n, 8'd1);
        step(1);
        check("pw_idle", state, 8'd1);

        // Reserved action: move latched, no state change
        press(2'b11, 2'b01);
        check("rsv_state", state, 8'd1);
        check("rsv_pmove", p_move, 8'd1);
        step(1);

        // Player attack, AI survives, player survives
        press(2'b00, 2'b10);
        check("atk_state", state, 8'd2);
        check("atk_pmove", p_move, 8'd2);
        check("atk_dmg", app_ai_dmg, 8'd1);
        check("atk_target", target, 8'd1);
        check("atk_actr", actr, 8'd0);
        check("atk_stop", stop, 8'd1);
        step(1);
        check("pchk_state", state, 8'd3);
        check("pchk_dmg", app_ai_dmg, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("aidly_state", state, 8'd7);
        end
        step(1);
        check("aatk_state", state, 8'd8);
        check("aatk_pldmg", app_pl_dmg, 8'd1);
        check("aatk_actr", actr, 8'd1);
        check("aatk_target", target, 8'd0);
        step(1);
        check("achk_state", state, 8'd9);
        check("achk_pldmg", app_pl_dmg, 8'd0);
        check("achk_turn", turn_cnt, 8'd0);
        step(1);
        check("r1_state", state, 8'd1);
        check("r1_turn", turn_cnt, 8'd1);

        // Catch fails, AI turn follows
        press(2'b10, 2'b01);
        check("cf_state", state, 8'd5);
        check("cf_catch", catch, 8'd1);
        check("cf_target", target, 8'd1);
        step(1);
        check("cf_cchk", state, 8'd6);
        check("cf_catch0", catch, 8'd0);
        step(1);
        check("cf_aidly", state, 8'd7);
        step(3);
        check("cf_aatk", state, 8'd8);
        step(2);
        check("r2_state", state, 8'd1);
        check("r2_turn", turn_cnt, 8'd2);

        // Catch succeeds
        press(2'b10, 2'b00);
        check("cs_state", state, 8'd5);
        step(1);
        check("cs_cchk", state, 8'd6);
        catch_success = 1'b1;
        step(1);
        catch_success = 1'b0;
        check("cs_caught", state, 8'd12);
        check("cs_done", done, 8'd1);
        check("cs_result", result, 8'd2);
        step(2);
        check("cs_hold", state, 8'd12);
        rematch();

        // Win
        press(2'b00, 2'b11);
        check("win_pmove", p_move, 8'd3);
        ai_dead = 1'b1;
        step(1);
        check("win_pchk", state, 8'd3);
        step(1);
        ai_dead = 1'b0;
        check("win_state", state, 8'd10);
        check("win_done", done, 8'd1);
        check("win_result", result, 8'd0);
        rematch();

        // Lose
        press(2'b00, 2'b01);
        step(2);
        check("lose_aidly", state, 8'd7);
        step(3);
        check("lose_aatk", state, 8'd8);
        p_dead = 1'b1;
        step(1);
        check("lose_achk", state, 8'd9);
        step(1);
        p_dead = 1'b0;
        check("lose_state", state, 8'd11);
        check("lose_done", done, 8'd1);
        check("lose_result", result, 8'd1);
        check("lose_turn", turn_cnt, 8'd0);
        rematch();

        // Timeout via heals; first heal holds go high through the whole round
        action = 2'b01;
        go     = 1'b1;
        step(1);
        check("hold_heal", state, 8'd4);
        check("hold_strobe", heal, 8'd1);
        check("hold_actr", actr, 8'd0);
        step(1);
        check("hold_heal0", heal, 8'd0);
        step(5);
        check("hold_pwait", state, 8'd1);
        check("hold_turn", turn_cnt, 8'd1);
        step(2);
        check("hold_noact", state, 8'd1);
        go = 1'b0;
        step(1);
        heal_round();
        check("h2_turn", turn_cnt, 8'd2);
        heal_round();
        check("h3_turn", turn_cnt, 8'd3);
        check("h3_state", state, 8'd1);
`ifdef PBS_HEAL_LIMIT_EN
        press(2'b01, 2'b00);
        check("deny_pulse", heal_denied, 8'd1);
        check("deny_state", state, 8'd1);
        check("deny_heal", heal, 8'd0);
        check("deny_turn", turn_cnt, 8'd3);
        step(1);
        check("deny_clr", heal_denied, 8'd0);
        press(2'b00, 2'b00);
        check("last_atk", state, 8'd2);
        step(6);
        check("last_achk", state, 8'd9);
        step(1);
`else
        heal_round();
`endif
        check("to_state", state, 8'd13);
        check("to_done", done, 8'd1);
        check("to_result", result, 8'd3);
        check("to_turn", turn_cnt, 8'd4);
        check("to_denied", heal_denied, 8'd0);
        step(2);
        check("to_hold", state, 8'd13);
        check("to_sat", turn_cnt, 8'd4);
        rematch();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pbs_battle_ctrl.md
Name: pbs_battle_ctrl

Overview:
- Turn-sequencing controller for the PBS battle datapath; the control end of the datapath's control/status interface.
- Drives trainer select, heal, catch, damage-apply, RNG stop, AI-HP load and datapath reset.
- Consumes the ai_dead, p_dead and catch_success status flags.
- Turns a player button/selection into one resolved player turn, then an AI turn, and reports battle outcome to display logic.

Parameters:
- MAX_TURNS, 15: completed full rounds (player + AI) before timeout; 1..15.
- AI_DELAY, 3: idle cycles in S_AIDLY before the AI attacks; 0..15.
- HEAL_MAX, 3: heal uses per battle (only with PBS_HEAL_LIMIT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- go  in  1  player confirm, level; rising edge detected internally
- action  in  2  00 attack, 01 heal, 10 catch, 11 reserved
- move_sel  in  2  player move index
- ai_dead  in  1  datapath status
- p_dead  in  1  datapath status
- catch_success  in  1  datapath status; registered, valid the cycle after catch
- p_move  out  2  latched move_sel to datapath
- actr  out  1  0 player acting, 1 AI acting
- heal  out  1  heal strobe
- catch  out  1  catch strobe
- app_ai_dmg  out  1  apply damage to AI
- app_pl_dmg  out  1  apply damage to player
- load_ai_hp  out  1  AI HP load strobe
- target  out  1  1 when AI is target
- stop  out  1  freeze RNGs
- dp_rst_n  out  1  datapath reset, active-low
- state  out  4  current state code
- turn_cnt  out  4  completed rounds
- done  out  1  battle over
- result  out  2  valid when done: 00 win, 01 lose, 10 caught, 11 timeout
- heal_denied  out  1  one-cycle pulse; heal refused

Behaviour:
- Moore machine; all outputs decoded from the state register and counters.
- go is synchronised by one flop; go_rise = go & ~go_q.
- rst=0 at a clk edge sets state to S_LOAD and clears turn_cnt, the delay counter, go_q and the p_move latch (00).
- Each strobe is high for exactly one cycle. Strobes not listed for a state are 0.
- stop=1 in every state except S_PWAIT, so RNG values are frozen during resolution.
- States (state code):
  - S_LOAD(0): dp_rst_n=0, load_ai_hp=1; clears turn_cnt and heal count; -> S_PWAIT.
  - S_PWAIT(1): stop=0.
    - On go_rise: latch move_sel into p_move.
    - action 00 -> S_PATK; 01 -> S_PHEAL; 10 -> S_PCATCH; 11 -> stay, no effect.
    - No go_rise: stay.
  - S_PATK(2): actr=0, target=1, app_ai_dmg=1 -> S_PCHK.
  - S_PCHK(3): ai_dead=1 -> S_WIN; else -> S_AIDLY.
  - S_PHEAL(4): heal=1, actr=0 -> S_AIDLY.
  - S_PCATCH(5): catch=1, target=1 -> S_CCHK.
  - S_CCHK(6): catch_success=1 -> S_CAUGHT; else -> S_AIDLY.
  - S_AIDLY(7): delay counter counts 0..AI_DELAY-1, then -> S_AATK. AI_DELAY=0 gives one cycle in this state. Counter clears on exit.
  - S_AATK(8): actr=1, target=0, app_pl_dmg=1 -> S_ACHK.
  - S_ACHK(9):
    - p_dead=1 -> S_LOSE.
    - Else if turn_cnt==MAX_TURNS-1 -> S_TIMEOUT, with turn_cnt incremented to MAX_TURNS.
    - Else turn_cnt+1 -> S_PWAIT.
  - S_WIN(10), S_LOSE(11), S_CAUGHT(12), S_TIMEOUT(13): done=1, result per code. go_rise -> S_LOAD (rematch). Otherwise hold.
  - Codes 14 and 15 are illegal -> S_LOAD.
- ai_dead and p_dead are checked only in the *CHK states, one cycle after the damage strobe. The datapath HP register updates on the strobe edge.
- go held high across a turn causes no second action; a new rising edge is required.
- go_rise outside S_PWAIT and the terminal states is ignored.
- turn_cnt saturates; it is never incremented past MAX_TURNS.

Optional Feature:
- Macro: PBS_HEAL_LIMIT_EN.
- With the macro:
  - A heal counter (2 bits minimum, sized for HEAL_MAX) increments in S_PHEAL and clears in S_LOAD.
  - In S_PWAIT, go_rise with action 01 and count==HEAL_MAX pulses heal_denied for one cycle. The state stays S_PWAIT and no turn is consumed.
- Without the macro: heals are unlimited, heal_denied is tied 0, and no counter exists.

Test Plan:
- Reset sequence: rst=0 for 2 cycles, then 1 -> S_LOAD with dp_rst_n=0 and load_ai_hp=1 for one cycle, then state=1, stop=0, done=0.
- Player attack, ai_dead=0, AI_DELAY=3: go_rise with action=00, move_sel=10 -> next cycle p_move=10, app_ai_dmg=1. Then S_PCHK, 3 cycles of S_AIDLY, app_pl_dmg=1 with actr=1, then S_ACHK with p_dead=0 -> turn_cnt=1, back to state 1.
- Win: ai_dead=1 in S_PCHK -> state=10, done=1, result=00; go_rise -> state=0.
- Catch: action=10 -> catch=1 one cycle; catch_success=1 in S_CCHK -> state=12, result=10; with catch_success=0 -> S_AIDLY.
- Timeout: MAX_TURNS=2, always heal, p_dead=0 -> after 2nd S_ACHK, state=13, result=11, turn_cnt=2. Holding go high gives only one action per rising edge.
- With PBS_HEAL_LIMIT_EN, HEAL_MAX=3: 4th heal request -> heal_denied=1 for one cycle, heal=0, state stays 1, turn_cnt unchanged.
